// File: rtl/vector_mem_access.sv
// Purpose: memory-stage sequencer that issues scalar loads/stores as 1 beat and vector ones as 4 consecutive 32-bit beats.
// Latency: a request accepted in cycle T issues beats from T+1 and reaches RESP one cycle after its last acked beat.
// Backpressure: each beat is held until mem_ack; o_stall freezes upstream from acceptance until the RESP cycle.
module vector_mem_access (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_rmem,
  input  logic         i_wmem,
  input  logic         i_vf,
  input  logic [31:0]  i_addr,
  input  logic [127:0] i_wdata,
  input  logic [3:0]   i_dest,
  input  logic         i_flush,
  output logic         o_mem_req,
  output logic         o_mem_we,
  output logic [31:0]  o_mem_addr,
  output logic [31:0]  o_mem_wdata,
  input  logic         i_mem_ack,
  input  logic [31:0]  i_mem_rdata,
  output logic         o_stall,
  output logic         o_wb_valid,
  output logic         o_wb_vf,
  output logic [3:0]   o_wb_dest,
  output logic [127:0] o_wb_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BEAT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic [1:0]     r_idx;
  logic [1:0]     r_last;
  logic [31:0]    r_base;
  logic [127:0]   r_wdata;
  logic           r_vf;
  logic [3:0]     r_dest;
  logic           r_op_st;
  logic           r_kill;
  logic [127:0]   r_buf;

  logic           r_wb_valid;
  logic           r_wb_vf;
  logic [3:0]     r_wb_dest;
  logic [127:0]   r_wb_data;

  logic           w_start;
  logic           w_beat_done;
  logic           w_last_done;
  logic [127:0]   w_buf_upd;
  logic [127:0]   w_wb_data;

  // A new instruction is only taken in IDLE, and a jump-taken flush kills it before any traffic.
  assign w_start     = (i_rmem | i_wmem) & ~i_flush;
  assign w_beat_done = (r_state == S_BEAT) & i_mem_ack;
  assign w_last_done = w_beat_done & (r_idx == r_last);

  // Load buffer with the lane of the current beat replaced by the returning read data.
  always_comb begin
    w_buf_upd = r_buf;
    w_buf_upd[{r_idx, 5'b00000} +: 32] = i_mem_rdata;
  end

  // Scalar loads only return lane 0; upper lanes are zero-filled.
  assign w_wb_data = r_vf ? w_buf_upd : {96'h0, w_buf_upd[31:0]};

  // Stall is the only combinational output; forced low while reset is asserted.
  assign o_stall = i_rst & (((r_state == S_IDLE) & w_start) | (r_state == S_BEAT));

  // State register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and memory-port decode from the registered beat context.
  always_comb begin
    w_state_nxt = r_state;
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = 32'h0;
    o_mem_wdata = 32'h0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_BEAT;
        end
      end
      S_BEAT: begin
        o_mem_req   = 1'b1;
        o_mem_we    = r_op_st;
        // Beat address wraps modulo 2^32 naturally through the 32-bit add.
        o_mem_addr  = r_base + {28'h0, r_idx, 2'b00};
        o_mem_wdata = r_wdata[{r_idx, 5'b00000} +: 32];
        if (w_last_done) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Capture the request on acceptance, then advance the beat index and fill the load buffer on each ack.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_idx   <= 2'd0;
      r_last  <= 2'd0;
      r_base  <= 32'h0;
      r_wdata <= 128'h0;
      r_vf    <= 1'b0;
      r_dest  <= 4'h0;
      r_op_st <= 1'b0;
      r_buf   <= 128'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_base  <= i_addr & 32'hFFFF_FFFC;
            r_wdata <= i_wdata;
            r_vf    <= i_vf;
            r_dest  <= i_dest;
            r_op_st <= i_wmem;
            r_idx   <= 2'd0;
            r_last  <= i_vf ? 2'd3 : 2'd0;
            r_buf   <= 128'h0;
          end
        end
        S_BEAT: begin
          if (i_mem_ack) begin
            if (!r_op_st) begin
              r_buf <= w_buf_upd;
            end
            if (r_idx != r_last) begin
              r_idx <= r_idx + 2'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Kill flag: a flush while the access is in flight lets the beats finish but drops the writeback.
  // A flush arriving in RESP has nothing left to suppress, since the flag clears as IDLE is entered.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_kill <= 1'b0;
    end else if (r_state == S_RESP) begin
      r_kill <= 1'b0;
    end else if ((r_state == S_BEAT) && i_flush) begin
      r_kill <= 1'b1;
    end
  end

  // Writeback registers load as the final load beat completes, so the one-cycle strobe lands in RESP;
  // a flush in that same final beat cycle still counts as a kill.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wb_valid <= 1'b0;
      r_wb_vf    <= 1'b0;
      r_wb_dest  <= 4'h0;
      r_wb_data  <= 128'h0;
    end else begin
      r_wb_valid <= 1'b0;
      if (w_last_done && !r_op_st && !r_kill && !i_flush) begin
        r_wb_valid <= 1'b1;
        r_wb_vf    <= r_vf;
        r_wb_dest  <= r_dest;
        r_wb_data  <= w_wb_data;
      end
    end
  end

  assign o_wb_valid = r_wb_valid;
  assign o_wb_vf    = r_wb_vf;
  assign o_wb_dest  = r_wb_dest;
  assign o_wb_data  = r_wb_data;

endmodule
